// File: rtl/unit_deploy_scheduler.sv
// Friendly unit slot controller: gold budget, lowest-free-slot allocation, tick strobe sequencing.
// Optional buy cooldown is enabled by defining DEPLOY_COOLDOWN_EN.
module unit_deploy_scheduler #(
    parameter int         NUM_SLOTS   = 4,
    parameter logic [9:0] COST1       = 10'd20,
    parameter logic [9:0] COST2       = 10'd40,
    parameter logic [9:0] COST3       = 10'd80,
    parameter logic [9:0] INCOME      = 10'd1,
    parameter logic [9:0] GOLD_MAX    = 10'd999,
    parameter int         ACK_TIMEOUT = 4
`ifdef DEPLOY_COOLDOWN_EN
    ,
    parameter int         COOLDOWN    = 8
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gameTick,
    input  logic                   buyBtn,
    input  logic                   SW1,
    input  logic                   SW2,
    input  logic                   SW3,
    input  logic [2*NUM_SLOTS-1:0] slotType,
    input  logic [9*NUM_SLOTS-1:0] slotPos,
    output logic [NUM_SLOTS-1:0]   purchase,
    output logic                   damageSCEN,
    output logic                   moveSCEN,
    output logic [9:0]             gold,
    output logic [8:0]             friendFront,
    output logic                   busy,
    output logic                   buyReject
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int ACK_W = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_TICK_DMG, S_TICK_MOVE, S_CHECK, S_GRANT, S_WAIT_ACK
    } state_t;

    state_t               r_state;
    logic                 r_tick_pend;
    logic                 r_buy_pend;
    logic [2:0]           r_sw;
    logic [IDX_W-1:0]     r_idx;
    logic [9:0]           r_cost;
    logic [9:0]           r_gold;
    logic [ACK_W-1:0]     r_ack_cnt;
    logic [NUM_SLOTS-1:0] r_purchase;
    logic                 r_damage;
    logic                 r_move;
    logic                 r_busy;
    logic                 r_reject;
    logic [8:0]           r_front;

    logic [1:0]       w_slot_type [NUM_SLOTS];
    logic [8:0]       w_slot_pos  [NUM_SLOTS];
    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;
    logic [8:0]       w_front;
    logic [9:0]       w_cost;
    logic             w_sw_onehot;
    logic [10:0]      w_inc_sum;
    logic [10:0]      w_ref_sum;
    logic [9:0]       w_gold_inc;
    logic [9:0]       w_gold_ref;
    logic             w_ack;
    logic             w_tick_go;
    logic             w_ack_ok;
    logic             w_cd_block;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign w_slot_type[gi] = slotType[2*gi +: 2];
            assign w_slot_pos[gi]  = slotPos[9*gi +: 9];
        end
    endgenerate

    // Descending scan so the lowest free index is the one left standing.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_slot_type[i] == 2'b00) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_front = 9'h1FF;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_slot_type[i] != 2'b00 && w_slot_pos[i] < w_front)
                w_front = w_slot_pos[i];
        end
    end

    always_comb begin
        w_sw_onehot = 1'b1;
        case (r_sw)
            3'b001:  w_cost = COST1;
            3'b010:  w_cost = COST2;
            3'b100:  w_cost = COST3;
            default: begin
                w_cost      = '0;
                w_sw_onehot = 1'b0;
            end
        endcase
    end

    assign w_inc_sum  = {1'b0, r_gold} + {1'b0, INCOME};
    assign w_ref_sum  = {1'b0, r_gold} + {1'b0, r_cost};
    assign w_gold_inc = (w_inc_sum > {1'b0, GOLD_MAX}) ? GOLD_MAX : w_inc_sum[9:0];
    assign w_gold_ref = (w_ref_sum > {1'b0, GOLD_MAX}) ? GOLD_MAX : w_ref_sum[9:0];
    assign w_ack      = (w_slot_type[r_idx] != 2'b00);
    assign w_tick_go  = (r_state == S_IDLE) && r_tick_pend;
    assign w_ack_ok   = (r_state == S_WAIT_ACK) && w_ack;

`ifdef DEPLOY_COOLDOWN_EN
    localparam int CD_W = $clog2(COOLDOWN + 1);
    logic [CD_W-1:0] r_cd_cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            r_cd_cnt <= '0;
        else if (w_ack_ok)
            r_cd_cnt <= CD_W'(COOLDOWN);
        else if (w_tick_go && r_cd_cnt != '0)
            r_cd_cnt <= r_cd_cnt - 1'b1;
    end
    assign w_cd_block = (r_cd_cnt != '0);
`else
    assign w_cd_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_tick_pend <= 1'b0;
            r_buy_pend  <= 1'b0;
            r_sw        <= '0;
            r_idx       <= '0;
            r_cost      <= '0;
            r_gold      <= COST1;
            r_ack_cnt   <= '0;
            r_purchase  <= '0;
            r_damage    <= 1'b0;
            r_move      <= 1'b0;
            r_busy      <= 1'b0;
            r_reject    <= 1'b0;
            r_front     <= 9'h1FF;
        end else begin
            r_front    <= w_front;
            r_purchase <= '0;
            r_damage   <= 1'b0;
            r_move     <= 1'b0;
            r_reject   <= 1'b0;
            if (gameTick)
                r_tick_pend <= 1'b1;
            if (buyBtn && !r_buy_pend) begin
                r_buy_pend <= 1'b1;
                r_sw       <= {SW3, SW2, SW1};
            end
            case (r_state)
                S_IDLE: begin
                    if (r_tick_pend) begin
                        r_tick_pend <= 1'b0;
                        r_damage    <= 1'b1;
                        r_gold      <= w_gold_inc;
                        r_state     <= S_TICK_DMG;
                    end else if (r_buy_pend) begin
                        r_buy_pend <= 1'b0;
                        r_state    <= S_CHECK;
                    end
                end
                S_TICK_DMG: begin
                    r_move  <= 1'b1;
                    r_state <= S_TICK_MOVE;
                end
                S_TICK_MOVE: r_state <= S_IDLE;
                S_CHECK: begin
                    if (!w_sw_onehot || !w_free_found || r_gold < w_cost || w_cd_block) begin
                        r_reject <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_idx      <= w_free_idx;
                        r_cost     <= w_cost;
                        r_gold     <= r_gold - w_cost;
                        r_purchase <= NUM_SLOTS'(1) << w_free_idx;
                        r_busy     <= 1'b1;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_ack_cnt <= '0;
                    r_state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (w_ack) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                        r_gold   <= w_gold_ref;
                        r_reject <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign purchase    = r_purchase;
    assign damageSCEN  = r_damage;
    assign moveSCEN    = r_move;
    assign gold        = r_gold;
    assign friendFront = r_front;
    assign busy        = r_busy;
    assign buyReject   = r_reject;
endmodule

// File: tb/tb_unit_deploy_scheduler.sv
// Bench for unit_deploy_scheduler: directed scenarios plus randomized buys against a
// transaction-level gold/slot model.
module tb_unit_deploy_scheduler;
    localparam int NS          = 4;
    localparam int ACK_TIMEOUT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          gameTick = 1'b0;
    logic          buyBtn = 1'b0;
    logic          SW1 = 1'b0, SW2 = 1'b0, SW3 = 1'b0;
    logic [2*NS-1:0] slotType;
    logic [9*NS-1:0] slotPos;
    logic [NS-1:0] purchase;
    logic          damageSCEN, moveSCEN, busy, buyReject;
    logic [9:0]    gold;
    logic [8:0]    friendFront;

    int         n_vec = 0;
    int         n_err = 0;
    int         m_gold = 20;
    logic [1:0] m_type [NS];
    logic [8:0] m_pos  [NS];

    unit_deploy_scheduler dut (
        .clk(clk), .reset(reset), .gameTick(gameTick), .buyBtn(buyBtn),
        .SW1(SW1), .SW2(SW2), .SW3(SW3), .slotType(slotType), .slotPos(slotPos),
        .purchase(purchase), .damageSCEN(damageSCEN), .moveSCEN(moveSCEN),
        .gold(gold), .friendFront(friendFront), .busy(busy), .buyReject(buyReject)
    );

    always #5 clk = ~clk;

    always_comb begin
        slotType = '0;
        slotPos  = '0;
        for (int i = 0; i < NS; i++) begin
            slotType[2*i +: 2] = m_type[i];
            slotPos[9*i +: 9]  = m_pos[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int cost_of(input logic [2:0] sw);
        case (sw)
            3'b001:  return 20;
            3'b010:  return 40;
            3'b100:  return 80;
            default: return -1;
        endcase
    endfunction

    function automatic logic [1:0] type_of(input logic [2:0] sw);
        case (sw)
            3'b001:  return 2'b01;
            3'b010:  return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic int exp_front();
        int f = 511;
        for (int i = 0; i < NS; i++)
            if (m_type[i] != 2'b00 && int'(m_pos[i]) < f) f = int'(m_pos[i]);
        return f;
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        for (int i = 0; i < NS; i++) m_type[i] = 2'b00;
        step();
        step();
        reset = 1'b1;
        m_gold = 20;
    endtask

    task automatic do_tick();
        gameTick = 1'b1;
        step();
        gameTick = 1'b0;
        step();
        step();
        step();
        m_gold = (m_gold + 1 > 999) ? 999 : m_gold + 1;
    endtask

    // One buy transaction; ack_delay 1..4 = slot reports that many clk after the pulse, -1 = never.
    task automatic do_buy(input string tag, input logic [2:0] sw, input int ack_delay);
        int cost, free, pcnt, rej, ack_at;
        logic [NS-1:0] pval;
        logic busy_at_p;
        bit accept, timely;
        cost = cost_of(sw);
        free = -1;
        for (int i = NS - 1; i >= 0; i--) if (m_type[i] == 2'b00) free = i;
        accept = (cost > 0) && (free >= 0) && (m_gold >= cost);
        timely = (ack_delay >= 1) && (ack_delay <= ACK_TIMEOUT);
        step();
        step();
        {SW3, SW2, SW1} = sw;
        buyBtn = 1'b1;
        step();
        buyBtn = 1'b0;
        {SW3, SW2, SW1} = 3'($urandom);
        pcnt = 0; rej = 0; pval = '0; ack_at = -1; busy_at_p = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (purchase != '0) begin
                pcnt++;
                pval = purchase;
                busy_at_p = busy;
                if (ack_delay >= 1) ack_at = c + ack_delay - 1;
            end
            if (buyReject) rej++;
            if (c == ack_at && free >= 0) m_type[free] = type_of(sw);
            step();
        end
        n_vec++;
        if (pcnt !== (accept ? 1 : 0)) begin
            n_err++;
            $display("FAIL %s purchase_count: got %0d expected %0d", tag, pcnt, accept ? 1 : 0);
        end
        if (accept) begin
            n_vec++;
            if (pval !== (NS'(1) << free)) begin
                n_err++;
                $display("FAIL %s purchase_slot: got %b expected %b", tag, pval, NS'(1) << free);
            end
            n_vec++;
            if (busy_at_p !== 1'b1) begin
                n_err++;
                $display("FAIL %s busy_in_grant: got %b expected 1", tag, busy_at_p);
            end
        end
        n_vec++;
        if (rej !== ((accept && timely) ? 0 : 1)) begin
            n_err++;
            $display("FAIL %s reject_cycles: got %0d expected %0d", tag, rej, (accept && timely) ? 0 : 1);
        end
        if (accept && timely) m_gold -= cost;
        n_vec++;
        if (gold !== 10'(m_gold)) begin
            n_err++;
            $display("FAIL %s gold: got %0d expected %0d", tag, gold, m_gold);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_end: got %b expected 0", tag, busy);
        end
        n_vec++;
        if (friendFront !== 9'(exp_front())) begin
            n_err++;
            $display("FAIL %s friendFront: got %0d expected %0d", tag, friendFront, exp_front());
        end
        $display("buy %s sw=%b ack=%0d accept=%0b timely=%0b gold=%0d", tag, sw, ack_delay, accept, timely, gold);
    endtask

    task automatic test_reset();
        for (int i = 0; i < NS; i++) m_pos[i] = 9'(40 * i + 5);
        reset = 1'b0;
        for (int i = 0; i < NS; i++) m_type[i] = 2'b00;
        step();
        step();
        n_vec++;
        if (gold !== 10'd20) begin n_err++; $display("FAIL reset_gold: got %0d expected 20", gold); end
        n_vec++;
        if (friendFront !== 9'h1FF) begin n_err++; $display("FAIL reset_front: got %h expected 1ff", friendFront); end
        n_vec++;
        if ({purchase, damageSCEN, moveSCEN, busy, buyReject} !== '0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 0", {purchase, damageSCEN, moveSCEN, busy, buyReject});
        end
        reset = 1'b1;
        m_gold = 20;
        $display("reset gold=%0d front=%h", gold, friendFront);
    endtask

    task automatic test_tick();
        int dcyc = -1, mcyc = -1, dn = 0, mn = 0;
        gameTick = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            gameTick = 1'b0;
            if (damageSCEN) begin dn++; dcyc = c; end
            if (moveSCEN) begin mn++; mcyc = c; end
        end
        m_gold = (m_gold + 1 > 999) ? 999 : m_gold + 1;
        n_vec++;
        if (dn !== 1 || dcyc !== 2) begin n_err++; $display("FAIL tick_damage: got %0d@%0d expected 1@2", dn, dcyc); end
        n_vec++;
        if (mn !== 1 || mcyc !== 3) begin n_err++; $display("FAIL tick_move: got %0d@%0d expected 1@3", mn, mcyc); end
        n_vec++;
        if (gold !== 10'(m_gold)) begin n_err++; $display("FAIL tick_gold: got %0d expected %0d", gold, m_gold); end
        $display("tick damage@%0d move@%0d gold=%0d", dcyc, mcyc, gold);
    endtask

    task automatic test_tick_and_buy();
        int dfirst = -1, mfirst = -1, dn = 0, mn = 0, pcyc = -1, pn = 0, rej = 0, dbusy = 0;
        apply_reset();
        step();
        {SW3, SW2, SW1} = 3'b001;
        gameTick = 1'b1;
        buyBtn = 1'b1;
        step();
        buyBtn = 1'b0;
        gameTick = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (damageSCEN) begin dn++; if (dfirst < 0) dfirst = c; if (busy) dbusy++; end
            if (moveSCEN) begin mn++; if (mfirst < 0) mfirst = c; end
            if (purchase != '0) begin pn++; pcyc = c; end
            if (buyReject) rej++;
            gameTick = (pcyc >= 0) && (c == pcyc + 1 || c == pcyc + 2);
            step();
        end
        gameTick = 1'b0;
        m_gold = 22;
        n_vec++;
        if (dfirst !== 2 || mfirst !== 3) begin
            n_err++;
            $display("FAIL tickbuy_order: got dmg@%0d move@%0d expected dmg@2 move@3", dfirst, mfirst);
        end
        n_vec++;
        if (pn !== 1 || pcyc <= mfirst) begin
            n_err++;
            $display("FAIL tickbuy_purchase: got %0d@%0d expected 1 after move@%0d", pn, pcyc, mfirst);
        end
        n_vec++;
        if (dn !== 2 || mn !== 2 || dbusy !== 0) begin
            n_err++;
            $display("FAIL tickbuy_merge: got dmg=%0d move=%0d dmg_busy=%0d expected 2 2 0", dn, mn, dbusy);
        end
        n_vec++;
        if (rej !== 1) begin n_err++; $display("FAIL tickbuy_timeout_reject: got %0d expected 1", rej); end
        n_vec++;
        if (gold !== 10'(m_gold)) begin n_err++; $display("FAIL tickbuy_refund_gold: got %0d expected %0d", gold, m_gold); end
        $display("tickbuy dmg@%0d move@%0d purchase@%0d reject=%0d gold=%0d", dfirst, mfirst, pcyc, rej, gold);
    endtask

    task automatic test_front();
        int exp_old;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_old = exp_front();
            for (int i = 0; i < NS; i++) begin
                m_type[i] = (k == 0) ? 2'b00 : 2'($urandom);
                m_pos[i]  = (k == 1 && i == 2) ? 9'd0 : 9'($urandom_range(0, 511));
            end
            #1;
            n_vec++;
            if (friendFront !== 9'(exp_old)) begin
                n_err++;
                $display("FAIL front_hold: got %0d expected %0d", friendFront, exp_old);
            end
            step();
            n_vec++;
            if (friendFront !== 9'(exp_front())) begin
                n_err++;
                $display("FAIL front_update: got %0d expected %0d", friendFront, exp_front());
            end
            $display("front iter=%0d value=%0d", k, friendFront);
        end
    endtask

    task automatic test_random();
        logic [2:0] sw_tab [10] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                                     3'b011, 3'b000, 3'b101, 3'b111};
        int ack;
        for (int it = 0; it < 25; it++) begin
            for (int k = $urandom_range(0, 30); k > 0; k--) do_tick();
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 2) == 0) m_type[i] = 2'b00;
                m_pos[i] = 9'($urandom_range(0, 511));
            end
            ack = $urandom_range(0, 4);
            do_buy("rand", sw_tab[$urandom_range(0, 9)], (ack == 0) ? -1 : ack);
        end
    endtask

    task automatic test_reset_mid_purchase();
        int seen = 0;
        apply_reset();
        for (int k = 0; k < 20; k++) do_tick();
        {SW3, SW2, SW1} = 3'b001;
        buyBtn = 1'b1;
        step();
        buyBtn = 1'b0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            if (purchase != '0) seen = 1;
            else step();
        end
        n_vec++;
        if (seen !== 1) begin n_err++; $display("FAIL midreset_purchase_seen: got %0d expected 1", seen); end
        reset = 1'b0;
        step();
        step();
        n_vec++;
        if (gold !== 10'd20 || busy !== 1'b0 || purchase !== '0) begin
            n_err++;
            $display("FAIL midreset_state: got gold=%0d busy=%b purchase=%b expected 20 0 0", gold, busy, purchase);
        end
        reset = 1'b1;
        m_gold = 20;
        for (int i = 0; i < NS; i++) m_type[i] = 2'b00;
        $display("midreset gold=%0d busy=%b", gold, busy);
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 985; k++) do_tick();
        n_vec++;
        if (gold !== 10'd999) begin n_err++; $display("FAIL sat_gold: got %0d expected 999", gold); end
        $display("saturation gold=%0d", gold);
        do_buy("sat_sw3", 3'b100, 2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NS; i++) begin m_type[i] = 2'b00; m_pos[i] = 9'd0; end
        test_reset();
        do_buy("exact_sw1", 3'b001, 1);
        test_tick();
        apply_reset();
        for (int k = 0; k < 10; k++) do_tick();
        do_buy("short_sw3", 3'b100, 1);
        do_buy("short_sw2", 3'b010, 1);
        do_buy("sw1_sw2", 3'b011, 1);
        do_buy("no_sw", 3'b000, 1);
        for (int i = 0; i < NS; i++) m_type[i] = 2'b01;
        do_buy("all_full", 3'b001, 1);
        apply_reset();
        for (int k = 0; k < 40; k++) do_tick();
        do_buy("ack_at_limit", 3'b001, ACK_TIMEOUT);
        do_buy("never_ack", 3'b001, -1);
        do_buy("ack_fast_sw2", 3'b010, 1);
        test_tick_and_buy();
        test_front();
        test_random();
        test_reset_mid_purchase();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
